vram_write_buffer: RTL and testbench

- CPU-side writer for GPU VRAM; the producer end of the VRAM `address`/`data` interface that the background, foreground and object renderers consume.
- Accepts byte writes from the CPU bus at any time and decodes the 12-bit VRAM address into a region.
- Queues writes in a FIFO and commits them to VRAM only while `writable` is high, so renderers never see VRAM change mid-scanline.
- Sits between the CPU bus bridge and the renderer memories inside the GPU top level.

---
 rtl/vram_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 45 ++++
 rtl/vram_write_buffer.sv | 136 +++++++++++++
 tb/tb_vram_write_buffer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and constants for the CPU-side VRAM write path.
package vram_pkg;

    localparam int unsigned VRAM_AW  = 12;
    localparam int unsigned OFFSET_W = 10;
    localparam int unsigned DATA_W   = 8;

    typedef enum logic [1:0] {
        REGION_PMF  = 2'd0,
        REGION_PMB  = 2'd1,
        REGION_NTBL = 2'd2,
        REGION_OBM  = 2'd3
    } region_e;

    localparam logic [VRAM_AW-1:0] PMF_BASE  = 12'h000;
    localparam logic [VRAM_AW-1:0] PMF_SIZE  = 12'h200;
    localparam logic [VRAM_AW-1:0] PMB_BASE  = 12'h200;
    localparam logic [VRAM_AW-1:0] PMB_SIZE  = 12'h200;
    localparam logic [VRAM_AW-1:0] NTBL_BASE = 12'h400;
    localparam logic [VRAM_AW-1:0] NTBL_SIZE = 12'h400;
    localparam logic [VRAM_AW-1:0] OBM_BASE  = 12'h800;
    localparam logic [VRAM_AW-1:0] OBM_SIZE  = 12'h100;

    typedef struct packed {
        region_e               region;
        logic [OFFSET_W-1:0]   offset;
        logic [DATA_W-1:0]     data;
    } vram_entry_t;

    localparam int unsigned ENTRY_W = $bits(vram_entry_t);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } wb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= CNT_W'(count + CNT_W'(do_push) - CNT_W'(do_pop));
        end
    end

    // Storage needs no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vram_write_buffer.sv
// CPU-to-VRAM write buffer: decodes, queues and commits bytes only inside the writable window.
// Optional sticky drop status behind VRAM_WRITE_BUFFER_STATUS_EN.
module vram_write_buffer
    import vram_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = VRAM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_wr_en,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_data,
    output logic          cpu_ready,
    input  logic          writable,
    output logic          vram_we,
    output logic [1:0]    vram_region,
    output logic [9:0]    vram_offset,
    output logic [7:0]    vram_data,
    output logic [6:0]    pending
`ifdef VRAM_WRITE_BUFFER_STATUS_EN
    ,
    input  logic          status_clr,
    output logic [1:0]    status
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [VRAM_AW-1:0]  addr;
    logic                in_range;
    region_e             dec_region;
    logic [OFFSET_W-1:0] dec_offset;
    logic                push;
    logic [CNT_W-1:0]    count;
    logic [ENTRY_W-1:0]  fifo_rdata;
    vram_entry_t         push_entry;
    vram_entry_t         head;
    vram_entry_t         last_q;
    vram_entry_t         shown;
    wb_state_e           state_q;
    wb_state_e           state_d;

    assign addr = VRAM_AW'(cpu_addr);

    // Region decode: each region matches when addr - base falls inside its size.
    always_comb begin
        in_range   = 1'b1;
        dec_region = REGION_PMF;
        dec_offset = '0;
        if (VRAM_AW'(addr - PMF_BASE) < PMF_SIZE) begin
            dec_region = REGION_PMF;
            dec_offset = OFFSET_W'(addr - PMF_BASE);
        end else if (VRAM_AW'(addr - PMB_BASE) < PMB_SIZE) begin
            dec_region = REGION_PMB;
            dec_offset = OFFSET_W'(addr - PMB_BASE);
        end else if (VRAM_AW'(addr - NTBL_BASE) < NTBL_SIZE) begin
            dec_region = REGION_NTBL;
            dec_offset = OFFSET_W'(addr - NTBL_BASE);
        end else if (VRAM_AW'(addr - OBM_BASE) < OBM_SIZE) begin
            dec_region = REGION_OBM;
            dec_offset = OFFSET_W'(addr - OBM_BASE);
        end else begin
            in_range = 1'b0;
        end
    end

    assign cpu_ready  = (count != CNT_W'(DEPTH));
    assign push       = cpu_wr_en && cpu_ready && in_range;
    assign push_entry = '{region: dec_region, offset: dec_offset, data: cpu_data};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (vram_we),
        .wdata (push_entry),
        .rdata (fifo_rdata),
        .count (count)
    );

    assign head = vram_entry_t'(fifo_rdata);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // DRAIN is entered a cycle after the window opens; commits are gated by writable directly.
    always_comb begin
        state_d = state_q;
        vram_we = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (writable) state_d = (count != '0) ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (!writable)          state_d = S_IDLE;
                else if (count != '0)   state_d = S_DRAIN;
            end
            S_DRAIN: begin
                vram_we = writable && (count != '0);
                if (!writable)
                    state_d = S_IDLE;
                else if ((count == '0) || ((count == CNT_W'(1)) && !push))
                    state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Last committed entry is shown while the queue is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         last_q <= '0;
        else if (vram_we) last_q <= head;
    end

    assign shown       = (count != '0) ? head : last_q;
    assign vram_region = shown.region;
    assign vram_offset = shown.offset;
    assign vram_data   = shown.data;
    assign pending     = 7'(count);

`ifdef VRAM_WRITE_BUFFER_STATUS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            status <= '0;
        else if (status_clr) status <= '0;
        else                 status <= status | {cpu_wr_en && !in_range,
                                                 cpu_wr_en && in_range && !cpu_ready};
    end
`endif

endmodule

// File: tb/tb_vram_write_buffer.sv
// Bench for vram_write_buffer: directed sequences, a decode table and random traffic against a queue model.
module tb_vram_write_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_wr_en;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_ready;
    logic        writable;
    logic        vram_we;
    logic [1:0]  vram_region;
    logic [9:0]  vram_offset;
    logic [7:0]  vram_data;
    logic [6:0]  pending;
`ifdef VRAM_WRITE_BUFFER_STATUS_EN
    logic        status_clr;
    logic [1:0]  status;
`endif

    vram_write_buffer #(.DEPTH(DEPTH), .AW(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_wr_en   (cpu_wr_en),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_ready   (cpu_ready),
        .writable    (writable),
        .vram_we     (vram_we),
        .vram_region (vram_region),
        .vram_offset (vram_offset),
        .vram_data   (vram_data),
        .pending     (pending)
`ifdef VRAM_WRITE_BUFFER_STATUS_EN
        ,
        .status_clr  (status_clr),
        .status      (status)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int region;
        int offset;
        int data;
    } ent_t;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
        bit          valid;
        int          region;
        int          offset;
    } dvec_t;

    ent_t       q[$];
    ent_t       last;
    bit         armed;
    logic [1:0] m_status;
    int         checks;
    int         errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Region map straight from the address ranges.
    function automatic bit decode(input logic [11:0] a, output ent_t e);
        int v;
        v = int'(a);
        e.data = 0;
        e.region = 0;
        e.offset = 0;
        if (v < 'h200)      begin e.region = 0; e.offset = v;          end
        else if (v < 'h400) begin e.region = 1; e.offset = v - 'h200;  end
        else if (v < 'h800) begin e.region = 2; e.offset = v - 'h400;  end
        else if (v < 'h900) begin e.region = 3; e.offset = v - 'h800;  end
        else return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_clear();
        q.delete();
        armed    = 1'b0;
        last     = '{0, 0, 0};
        m_status = 2'b00;
    endfunction

    task automatic compare();
        ent_t h;
        bit   exp_we;
        exp_we = rst && armed && writable && (q.size() > 0);
        h = (q.size() != 0) ? q[0] : last;
        chk("vram_we", 32'(vram_we), 32'(exp_we));
        chk("pending", 32'(pending), 32'(q.size()));
        chk("cpu_ready", 32'(cpu_ready), 32'(q.size() != DEPTH));
        chk("vram_region", 32'(vram_region), 32'(h.region));
        chk("vram_offset", 32'(vram_offset), 32'(h.offset));
        chk("vram_data", 32'(vram_data), 32'(h.data));
`ifdef VRAM_WRITE_BUFFER_STATUS_EN
        chk("status", 32'(status), 32'(m_status));
`endif
    endtask

    task automatic drive(input bit we, input logic [11:0] a, input logic [7:0] d, input bit w);
        cpu_wr_en = we;
        cpu_addr  = a;
        cpu_data  = d;
        writable  = w;
`ifdef VRAM_WRITE_BUFFER_STATUS_EN
        status_clr = 1'b0;
`endif
        #1;
        compare();
    endtask

    // Commit is possible only after an edge where the window was open and the queue
    // was non-empty both before and after that edge.
    task automatic tick();
        int   pre;
        bit   ok;
        bit   we_now;
        ent_t e;
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            pre    = q.size();
            ok     = decode(cpu_addr, e);
            e.data = int'(cpu_data);
            we_now = armed && writable && (pre > 0);
`ifdef VRAM_WRITE_BUFFER_STATUS_EN
            if (status_clr) m_status = 2'b00;
            else m_status = m_status | {cpu_wr_en && !ok, cpu_wr_en && ok && (pre == DEPTH)};
`endif
            if (we_now) last = q.pop_front();
            if (cpu_wr_en && ok && (pre < DEPTH)) q.push_back(e);
            armed = writable && (pre > 0) && (q.size() > 0);
        end
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n, input bit w);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 12'h0, 8'h0, w);
            tick();
        end
    endtask

    dvec_t dv[8];

    initial begin
        int commits;
        checks = 0;
        errors = 0;

        dv[0] = '{12'h1FF, 8'h11, 1'b1, 0, 'h1FF};
        dv[1] = '{12'h200, 8'h22, 1'b1, 1, 'h000};
        dv[2] = '{12'h7FF, 8'h33, 1'b1, 2, 'h3FF};
        dv[3] = '{12'h8FF, 8'h44, 1'b1, 3, 'h0FF};
        dv[4] = '{12'h900, 8'h55, 1'b0, 0, 0};
        dv[5] = '{12'h000, 8'h66, 1'b1, 0, 'h000};
        dv[6] = '{12'h400, 8'h77, 1'b1, 2, 'h000};
        dv[7] = '{12'hFFF, 8'h88, 1'b0, 0, 0};

        rst = 1'b0;
        model_clear();
        @(negedge clk);
        drive(1'b0, 12'h0, 8'h0, 1'b0);
        tick();
        rst = 1'b1;
        idle_cycles(2, 1'b0);

        // Window gating
        drive(1'b1, 12'h405, 8'hAB, 1'b0); tick();
        idle_cycles(2, 1'b0);
        drive(1'b0, 12'h0, 8'h0, 1'b1);
        chk("gate_no_we_first", 32'(vram_we), 32'd0);
        tick();
        drive(1'b0, 12'h0, 8'h0, 1'b1);
        chk("gate_we", 32'(vram_we), 32'd1);
        chk("gate_region", 32'(vram_region), 32'd2);
        chk("gate_offset", 32'(vram_offset), 32'h005);
        chk("gate_data", 32'(vram_data), 32'hAB);
        tick();
        drive(1'b0, 12'h0, 8'h0, 1'b1);
        chk("gate_pending", 32'(pending), 32'd0);
        tick();
        idle_cycles(1, 1'b0);

        // Full FIFO: 17th request dropped
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 12'h010 + 12'(i), 8'(i + 1), 1'b0);
            if (i == 16) chk("full_ready_low", 32'(cpu_ready), 32'd0);
            tick();
        end
        drive(1'b0, 12'h0, 8'h0, 1'b0);
        chk("full_pending", 32'(pending), 32'd16);
`ifdef VRAM_WRITE_BUFFER_STATUS_EN
        chk("full_status", 32'(status), 32'b01);
`endif
        tick();
        commits = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 12'h0, 8'h0, 1'b1);
            if (vram_we) commits++;
            tick();
        end
        chk("full_commits", 32'(commits), 32'd16);
        idle_cycles(1, 1'b0);

        // Window cut
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 12'h420 + 12'(i), 8'h30 + 8'(i), 1'b0);
            tick();
        end
        commits = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 12'h0, 8'h0, 1'b1);
            if (vram_we) commits++;
            tick();
        end
        chk("cut_first_window", 32'(commits), 32'd3);
        commits = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 12'h0, 8'h0, 1'b0);
            if (vram_we) commits++;
            tick();
        end
        chk("cut_closed", 32'(commits), 32'd0);
        commits = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 12'h0, 8'h0, 1'b1);
            if (vram_we) commits++;
            tick();
        end
        chk("cut_second_window", 32'(commits), 32'd7);
        idle_cycles(1, 1'b0);

        // Decode table
        foreach (dv[k]) begin
            drive(1'b1, dv[k].addr, dv[k].data, 1'b0);
            tick();
            drive(1'b0, 12'h0, 8'h0, 1'b0);
            chk("dec_pending", 32'(pending), 32'(dv[k].valid));
            if (dv[k].valid) begin
                chk("dec_region", 32'(vram_region), 32'(dv[k].region));
                chk("dec_offset", 32'(vram_offset), 32'(dv[k].offset));
                chk("dec_data", 32'(vram_data), 32'(dv[k].data));
            end
            tick();
            idle_cycles(3, 1'b1);
            idle_cycles(1, 1'b0);
        end
`ifdef VRAM_WRITE_BUFFER_STATUS_EN
        drive(1'b0, 12'h0, 8'h0, 1'b0);
        chk("dec_status", 32'(status), 32'b11);
        status_clr = 1'b1;
        tick();
        drive(1'b0, 12'h0, 8'h0, 1'b0);
        chk("status_cleared", 32'(status), 32'b00);
        tick();
`endif

        // Concurrent push while draining
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 12'h100 + 12'(i), 8'hC0 + 8'(i), 1'b0);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 12'h600 + 12'(i), 8'(i * 7), 1'b1);
            if (i >= 1) chk("conc_pending", 32'(pending), 32'd5);
            tick();
        end
        idle_cycles(8, 1'b1);
        idle_cycles(1, 1'b0);

        // Reset mid-drain with 5 entries still queued
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 12'h880 + 12'(i), 8'hE0 + 8'(i), 1'b0);
            tick();
        end
        idle_cycles(2, 1'b1);
        drive(1'b0, 12'h0, 8'h0, 1'b1);
        chk("pre_reset_pending", 32'(pending), 32'd5);
        rst = 1'b0;
        model_clear();
        #1;
        chk("rst_we", 32'(vram_we), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ready", 32'(cpu_ready), 32'd1);
        chk("rst_data", 32'(vram_data), 32'd0);
        tick();
        drive(1'b0, 12'h0, 8'h0, 1'b1);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 12'h0, 8'h0, 1'b1);
            chk("post_rst_no_we", 32'(vram_we), 32'd0);
            tick();
        end
        drive(1'b1, 12'h123, 8'h5A, 1'b1); tick();
        drive(1'b0, 12'h0, 8'h0, 1'b1);
        chk("post_rst_wait", 32'(vram_we), 32'd0);
        tick();
        drive(1'b0, 12'h0, 8'h0, 1'b1);
        chk("post_rst_commit", 32'(vram_we), 32'd1);
        chk("post_rst_data", 32'(vram_data), 32'h5A);
        tick();

        // Random traffic
        begin
            bit w;
            w = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                logic [11:0] a;
                if ($urandom_range(7) == 0) w = ~w;
                a = ($urandom_range(3) == 0) ? 12'($urandom) : 12'($urandom_range(12'h8FF));
                drive(($urandom_range(2) != 0), a, 8'($urandom), w);
`ifdef VRAM_WRITE_BUFFER_STATUS_EN
                status_clr = ($urandom_range(49) == 0);
`endif
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
